result_writeback: RTL

Write-back sink for the 6-bit CPU datapath. It accepts each ALU result, with its zero flag and destination register index, over a valid/ready handshake. Results are buffered in a small FIFO and committed in order, one per cycle, into a 4-entry register file. The controller reads operands A/B back from the register file through two combinational read ports and uses `pending` to detect in-flight results.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/result_fifo.sv | 56 +++++
 rtl/result_writeback.sv | 84 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the 6-bit CPU: widths and the write-back entry layout.
package cpu_pkg;

  localparam int DATA_W    = 6;
  localparam int OP_W      = 2;
  localparam int NREGS_DEF = 4;
  localparam int REG_IDX_W = $clog2(NREGS_DEF);

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic                 zf;
    logic [REG_IDX_W-1:0] rd;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/result_fifo.sv
// In-order result buffer; pointers carry one extra wrap bit so full and empty
// are told apart by comparing the MSB.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_full;
  logic             w_empty;
  logic             w_doPush;
  logic             w_doPop;

  assign w_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_empty  = (r_wrPtr == r_rdPtr);
  // clear wins over both ends, so a flush cycle never leaves a half-applied push or pop
  assign w_doPush = i_push & ~w_full  & ~i_clear;
  assign w_doPop  = i_pop  & ~w_empty & ~i_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  // storage needs no reset: a slot is only read after it has been written
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_head  = r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/result_writeback.sv
// Write-back sink: buffers ALU results and commits them in order into the
// register file, one per cycle, with two combinational read ports.
module result_writeback
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic                     in_zf,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic                     wb_hold,
  input  logic                     clear,
  input  logic [$clog2(NREGS)-1:0] rs_a_addr,
  input  logic [$clog2(NREGS)-1:0] rs_b_addr,
  output logic [DATA_W-1:0]        rs_a_data,
  output logic [DATA_W-1:0]        rs_b_data,
  output logic                     pending,
  output logic                     zero_flag,
  output logic [7:0]               commit_count
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_zeroFlag;
  logic [7:0]        r_commitCount;

  wb_entry_t w_pushEntry;
  wb_entry_t w_head;
  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_commit;

  always_comb begin
    w_pushEntry      = '0;
    w_pushEntry.data = in_result;
    w_pushEntry.zf   = in_zf;
    w_pushEntry.rd   = REG_IDX_W'(in_rd);
  end

  // no pass-through: a full buffer refuses a push even in a cycle it pops
  assign w_push   = in_valid & ~w_full;
  assign w_commit = ~w_empty & ~wb_hold & ~clear;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_commit),
    .i_clear (clear),
    .i_data  (w_pushEntry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_zeroFlag    <= 1'b0;
      r_commitCount <= '0;
    end else if (w_commit) begin
      r_regs[w_head.rd] <= w_head.data;
      r_zeroFlag        <= w_head.zf;
      r_commitCount     <= r_commitCount + 8'd1;
    end
  end

  // reads see committed state only; callers consult pending for in-flight writes
  assign rs_a_data    = r_regs[rs_a_addr];
  assign rs_b_data    = r_regs[rs_b_addr];
  assign in_ready     = ~w_full;
  assign pending      = ~w_empty;
  assign zero_flag    = r_zeroFlag;
  assign commit_count = r_commitCount;

endmodule
